// File: rtl/divider.sv
// Iterative 32-bit integer divider (DIV/DIVU): one quotient bit per cycle by restoring division.
// result = {remainder, quotient}, valid for one cycle on ready; annul flushes an in-flight operation.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy
);

  localparam int DATA_W = 32;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIVZERO = 2'd1;
  localparam logic [1:0] ON      = 2'd2;
  localparam logic [1:0] END     = 2'd3;

  logic [1:0]        state;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvsr;
  logic              neg_q;
  logic              neg_r;

  logic              load;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = x[DATA_W-1] ? -x : x;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign load  = (state == IDLE) && start && !annul;
  assign a_mag = signed_div ? mag(a) : a;
  assign b_mag = signed_div ? mag(b) : b;

  // Restoring step: shift the next dividend bit in, keep the difference only if it did not go negative.
  assign shifted = {rem, quo[DATA_W-1]};
  assign trial   = shifted - {1'b0, dvsr};
  assign rem_nxt = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quo_nxt = {quo[DATA_W-2:0], ~trial[DATA_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      rem    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            rem   <= '0;
            cnt   <= 5'd0;
            state <= (b == '0) ? DIVZERO : ON;
          end
        end
        DIVZERO: begin
          if (annul) begin
            state <= IDLE;
          end else begin
            result <= '0;
            state  <= END;
          end
        end
        ON: begin
          if (annul) begin
            state <= IDLE;
          end else begin
            rem <= rem_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result <= {cond_neg(rem_nxt, neg_r), cond_neg(quo_nxt, neg_q)};
              state  <= END;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand registers carry no reset; the FSM decides when their contents matter.
  always_ff @(posedge clk) begin
    if (load) begin
      quo   <= a_mag;
      dvsr  <= b_mag;
      neg_q <= signed_div & (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_r <= signed_div & a[DATA_W-1];
    end else if (state == ON) begin
      quo <= quo_nxt;
    end
  end

  assign ready = (state == END);
  assign busy  = (state == DIVZERO) || (state == ON);

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases plus randomized DIV/DIVU against an arithmetic model.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_res;

  always #5 clk = ~clk;

  divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .annul     (annul),
    .a         (a),
    .b         (b),
    .result    (result),
    .ready     (ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic with truncating division semantics.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic sg);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] res;
    if (y == 32'd0) return 64'h0;
    if (sg) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      res = {r[31:0], q[31:0]};
    end else begin
      ux = {32'd0, x};
      uy = {32'd0, y};
      uq = ux / uy;
      ur = ux % uy;
      res = {ur[31:0], uq[31:0]};
    end
    return res;
  endfunction

  // Present a request for one cycle (cycle 0), leave in cycle 1 with operands scrambled.
  task automatic start_op(input logic [31:0] aa, input logic [31:0] bb, input logic sg);
    a = aa;
    b = bb;
    signed_div = sg;
    start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    signed_div = 1'($urandom_range(1));
  endtask

  // Called in cycle 1; checks busy/ready/result every cycle up to the ready cycle and one beyond.
  task automatic finish_op(input string tag, input int lat, input logic [63:0] exp, input logic annul_end);
    for (int c = 1; c <= lat; c++) begin
      chk({tag, "_busy"}, 64'(busy), 64'(c < lat));
      chk({tag, "_ready"}, 64'(ready), 64'(c == lat));
      if (c == lat) begin
        chk({tag, "_result"}, result, exp);
        start = 1'b0;
        annul = annul_end;
      end else begin
        chk({tag, "_hold"}, result, last_res);
        start = 1'($urandom_range(1));
      end
      step();
    end
    annul = 1'b0;
    chk({tag, "_after"}, {62'd0, ready, busy}, 64'd0);
    chk({tag, "_kept"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    logic [31:0] x, y;
    logic        sg;
    logic [63:0] e;

    rst = 1'b1; start = 1'b1; annul = 1'b0; signed_div = 1'b0; a = 32'd5; b = 32'd1;
    step();
    step();
    chk("reset_result", result, 64'h0);
    chk("reset_flags", {62'd0, ready, busy}, 64'd0);
    rst = 1'b0;
    start = 1'b0;
    step();
    chk("reset_idle", {62'd0, ready, busy}, 64'd0);
    last_res = 64'h0;

    start_op(32'd5, 32'd0, 1'b0);
    finish_op("divu_5_0", 2, 64'h0, 1'b0);
    start_op(32'd100, 32'd7, 1'b0);
    finish_op("divu_100_7", 33, {32'd2, 32'd14}, 1'b0);
    start_op(32'hFFFFFFF9, 32'd2, 1'b1);
    finish_op("div_m7_2", 33, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b1);
    start_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
    finish_op("div_ovf", 33, {32'h0, 32'h80000000}, 1'b0);

    // Annul in cycle 10 of 1000/3, restart in cycle 11 with 9/4.
    start_op(32'd1000, 32'd3, 1'b0);
    for (int c = 1; c < 10; c++) begin
      chk("annul_run_busy", 64'(busy), 64'd1);
      chk("annul_run_ready", 64'(ready), 64'd0);
      step();
    end
    annul = 1'b1;
    chk("annul_c10_busy", 64'(busy), 64'd1);
    step();
    annul = 1'b0;
    chk("annul_c11_flags", {62'd0, ready, busy}, 64'd0);
    chk("annul_c11_result", result, last_res);
    start_op(32'd9, 32'd4, 1'b0);
    finish_op("annul_restart", 33, {32'd1, 32'd2}, 1'b0);

    // Annul while in DIVZERO.
    start_op(32'd5, 32'd0, 1'b0);
    annul = 1'b1;
    step();
    annul = 1'b0;
    chk("dz_annul_flags", {62'd0, ready, busy}, 64'd0);
    chk("dz_annul_result", result, last_res);

    // start together with annul in IDLE is dropped.
    a = 32'd7; b = 32'd1; start = 1'b1; annul = 1'b1;
    step();
    start = 1'b0; annul = 1'b0;
    chk("idle_annul_busy", {62'd0, ready, busy}, 64'd0);
    step();
    chk("idle_annul_busy2", {62'd0, ready, busy}, 64'd0);

    // Reset in cycle 20 of a division, with start asserted alongside.
    start_op(32'h12345678, 32'd3, 1'b0);
    for (int c = 1; c < 20; c++) step();
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_mid_flags", {62'd0, ready, busy}, 64'd0);
    chk("rst_mid_result", result, 64'h0);
    for (int c = 0; c < 20; c++) begin
      chk("rst_mid_quiet", {62'd0, ready, busy}, 64'd0);
      step();
    end
    last_res = 64'h0;

    for (int n = 0; n < 40; n++) begin
      x  = $urandom;
      sg = 1'($urandom_range(1));
      case ($urandom_range(7))
        0:       y = 32'd0;
        1:       y = 32'hFFFFFFFF;
        2:       y = 32'($urandom_range(15)) + 32'd1;
        3:       y = 32'hFFFFFFFF - 32'($urandom_range(15));
        default: y = $urandom;
      endcase
      if (n % 5 == 0) x = 32'h80000000;
      e = model(x, y, sg);
      start_op(x, y, sg);
      finish_op("rand", (y == 32'd0) ? 2 : 33, e, 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
